mux_nch_rr_reg: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer; next generation of the 2:1 gate-level mux.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/mux_nch_rr_reg.sv | 117 +++++++++++
 tb/tb_mux_nch_rr_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: masked scan over a doubled request vector,
// so the search from ptr wraps naturally back to channel 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [2*N_CH-1:0] dbl;
  logic [2*N_CH-1:0] mask;
  logic [2*N_CH-1:0] masked;
  logic              found;

  assign dbl    = {req, req};
  assign mask   = {(2*N_CH){1'b1}} << ptr;
  assign masked = dbl & mask;

  // Lowest set bit at or above ptr; the upper copy covers the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < 2*N_CH; k++) begin
      if (!found && masked[k]) begin
        found            = 1'b1;
        gnt_idx          = IW'(k % N_CH);
        gnt[k % N_CH]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nch_rr_reg.sv
// N-channel registered mux with valid/ready handshake and
// fixed-index or round-robin channel selection.
module mux_nch_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  generate
    if (SEL_W != clog2(N_CH) || N_CH < 2) begin : g_bad_params
      $error("mux_nch_rr_reg: SEL_W must equal clog2(N_CH), N_CH>=2");
    end
  endgenerate

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;

  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N_CH-1:0]  fix_gnt;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] data_sel;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel matches no channel, so it grants nothing.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) fix_gnt[i] = in_valid[i];
    end
  end

  always_comb begin
    grant = fix_gnt;
    gidx  = sel;
    unique case (1'b1)
      (mode == MODE_RR): begin
        grant = rr_gnt;
        gidx  = rr_idx;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) data_sel = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en  = !valid_q || out_ready;
  assign in_ready = grant & {N_CH{load_en & !rst}};
  assign xfer     = |(in_ready & in_valid);

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = data_sel;
      ch_d    = gidx;
      valid_d = 1'b1;
      ptr_d   = (gidx == SEL_W'(N_CH-1)) ? '0 : gidx + SEL_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nch_rr_reg.sv
// Bench for mux_nch_rr_reg: directed scenarios then random traffic,
// all checked against a cycle-level reference model.
module tb_mux_nch_rr_reg;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          out_ready;

  int passed = 0;
  int total  = 0;

  // reference model state
  int m_ptr = 0;
  int m_valid = 0;
  int m_data = 0;
  int m_ch = 0;

  always #5 clk = ~clk;

  mux_nch_rr_reg dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: pick the granted channel from the rules, or -1.
  function automatic int model_pick();
    int c;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic cyc();
    int g;
    logic [N-1:0] rdy;
    @(negedge clk);
    g = model_pick();
    rdy = '0;
    if (!rst && !(m_valid != 0 && !out_ready) && g >= 0) rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0;
    end else if (rdy != 0) begin
      m_data  = int'(in_data[g*W +: W]);
      m_ch    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0;
    in_data = '0; in_valid = '1; out_ready = 1'b1;

    // reset with all channels requesting
    cyc(); cyc();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);

    // fixed mode, sel=2
    rst = 1'b0; sel = 2'd2; in_data = 12'b110_101_011_000;
    #1 chk("fix_ready", 32'(in_ready), 32'b0100);
    cyc();
    chk("fix_data", 32'(out_data), 32'b101);
    chk("fix_ch", 32'(out_ch), 32'd2);
    cyc();
    chk("fix_sustain", 32'(out_valid), 32'd1);
    cyc();

    // backpressure for 3 cycles then release
    out_ready = 1'b0;
    in_data = 12'b110_111_011_000;
    cyc(); cyc(); cyc();
    chk("bp_hold", 32'(out_data), 32'b101);
    out_ready = 1'b1;
    cyc();
    chk("bp_next", 32'(out_data), 32'b111);

    // round robin from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    mode = 1'b1; in_data = 12'b100_011_010_001; in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_seq", 32'(out_ch), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'((k % 4) + 1));
    end

    // move ptr to 3, then sparse requests wrap to 0,1,0
    mode = 1'b0; sel = 2'd2; cyc();
    mode = 1'b1; in_valid = 4'b0011;
    cyc(); chk("wrap0", 32'(out_ch), 32'd0);
    cyc(); chk("wrap1", 32'(out_ch), 32'd1);
    cyc(); chk("wrap2", 32'(out_ch), 32'd0);
    mode = 1'b0; sel = 2'd3;
    #1 chk("sparse_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("sparse_drain", 32'(out_valid), 32'd0);

    // reset while a word is held and ch1 waits
    mode = 1'b1; in_valid = 4'b0011; cyc();
    out_ready = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; cyc();
    chk("midrst_first", 32'(out_ch), 32'd0);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      rst       = ($urandom_range(0, 40) == 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_data   = (N*W)'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
